// File: rtl/tdc_therm_decoder.sv
// TDC readout: normalize, bubble-correct and encode an alternating-polarity delay-line snapshot.
// Latency 4 edges (capture, normalize, bubble/detect, encode); global stall when out_valid && !out_ready; optional TDC_DEC_STATS_EN error counter.
module tdc_therm_decoder #(
  parameter int N_STAGES = 32,
  parameter int FINE_W   = 5,
  parameter int COARSE_W = 8
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [N_STAGES-1:0]        therm_in,
  input  logic                       phase_rev_in,
  input  logic [COARSE_W-1:0]        coarse_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COARSE_W+FINE_W-1:0] tdc_code,
  output logic                       out_err
`ifdef TDC_DEC_STATS_EN
  ,
  output logic [15:0]                err_cnt
`endif
);

  localparam int CNT_W = FINE_W + 1;

  logic                       stall, xfer;
  logic                       s1_valid_q, s1_valid_d, s1_phase_q, s1_phase_d;
  logic [N_STAGES-1:0]        s1_therm_q, s1_therm_d;
  logic [COARSE_W-1:0]        s1_coarse_q, s1_coarse_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [N_STAGES-1:0]        s2_norm_q, s2_norm_d;
  logic [COARSE_W-1:0]        s2_coarse_q, s2_coarse_d;
  logic                       s3_valid_q, s3_valid_d, s3_multi_q, s3_multi_d;
  logic [N_STAGES-1:0]        s3_c_q, s3_c_d;
  logic [COARSE_W-1:0]        s3_coarse_q, s3_coarse_d;
  logic                       out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [COARSE_W+FINE_W-1:0] tdc_code_q, tdc_code_d;

  logic [N_STAGES-1:0] norm, corr;
  logic [N_STAGES+1:0] norm_x;
  logic [N_STAGES:0]   corr_x;
  logic [CNT_W-1:0]    fall_cnt;
  logic                multi, enc_found, enc_err;
  logic [FINE_W-1:0]   enc_fine;

  always_comb begin
    norm = '0;
    for (int i = 0; i < N_STAGES; i++) norm[i] = s1_therm_q[i] ^ i[0] ^ s1_phase_q;
  end

  // Boundaries: a virtual passed stage below bit 0 and a virtual idle stage above the top.
  always_comb begin
    norm_x   = {1'b0, s2_norm_q, 1'b1};
    corr     = '0;
    for (int i = 0; i < N_STAGES; i++)
      corr[i] = (norm_x[i] & norm_x[i+1]) | (norm_x[i] & norm_x[i+2]) | (norm_x[i+1] & norm_x[i+2]);
    corr_x   = {1'b0, corr};
    fall_cnt = '0;
    for (int i = 0; i < N_STAGES; i++)
      if (corr_x[i] && !corr_x[i+1]) fall_cnt = fall_cnt + CNT_W'(1);
    multi    = (fall_cnt > CNT_W'(1));
  end

  always_comb begin
    enc_found = 1'b0;
    enc_fine  = FINE_W'(N_STAGES - 1);
    for (int i = 0; i < N_STAGES; i++) begin
      if (!enc_found && !s3_c_q[i]) begin
        enc_fine  = FINE_W'(i);
        enc_found = 1'b1;
      end
    end
    enc_err = enc_found ? s3_multi_q : 1'b1;
  end

  always_comb begin
    stall        = out_valid_q && !out_ready;
    sample_ready = !stall;
    xfer         = sample_valid && !stall;
    s1_valid_d  = s1_valid_q;  s1_therm_d  = s1_therm_q;  s1_phase_d = s1_phase_q;
    s1_coarse_d = s1_coarse_q;
    s2_valid_d  = s2_valid_q;  s2_norm_d   = s2_norm_q;   s2_coarse_d = s2_coarse_q;
    s3_valid_d  = s3_valid_q;  s3_c_d      = s3_c_q;      s3_multi_d  = s3_multi_q;
    s3_coarse_d = s3_coarse_q;
    out_valid_d = out_valid_q; tdc_code_d  = tdc_code_q;  out_err_d   = out_err_q;
    if (!stall) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_therm_d  = therm_in;
        s1_phase_d  = phase_rev_in;
        s1_coarse_d = coarse_in;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_norm_d   = norm;
        s2_coarse_d = s1_coarse_q;
      end
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_c_d      = corr;
        s3_multi_d  = multi;
        s3_coarse_d = s2_coarse_q;
      end
      out_valid_d = s3_valid_q;
      if (s3_valid_q) begin
        tdc_code_d = {s3_coarse_q, enc_fine};
        out_err_d  = enc_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid_q  <= 1'b0; s1_therm_q <= '0; s1_phase_q <= 1'b0; s1_coarse_q <= '0;
      s2_valid_q  <= 1'b0; s2_norm_q  <= '0; s2_coarse_q <= '0;
      s3_valid_q  <= 1'b0; s3_c_q     <= '0; s3_multi_q  <= 1'b0; s3_coarse_q <= '0;
      out_valid_q <= 1'b0; tdc_code_q <= '0; out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;  s1_therm_q <= s1_therm_d; s1_phase_q <= s1_phase_d;
      s1_coarse_q <= s1_coarse_d;
      s2_valid_q  <= s2_valid_d;  s2_norm_q  <= s2_norm_d;  s2_coarse_q <= s2_coarse_d;
      s3_valid_q  <= s3_valid_d;  s3_c_q     <= s3_c_d;     s3_multi_q  <= s3_multi_d;
      s3_coarse_q <= s3_coarse_d;
      out_valid_q <= out_valid_d; tdc_code_q <= tdc_code_d; out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign tdc_code  = tdc_code_q;
  assign out_err   = out_err_q;

`ifdef TDC_DEC_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid_q && out_ready && out_err_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Bench for tdc_therm_decoder: directed vectors, scripted backpressure, random stream, mid-stream reset.
module tb_tdc_therm_decoder;
  localparam int N = 32;

  logic        clk, rstb, sample_valid, sample_ready, phase_rev_in, out_valid, out_ready, out_err;
  logic [31:0] therm_in;
  logic [7:0]  coarse_in;
  logic [12:0] tdc_code;
  int total, bad, exp_errs;
`ifdef TDC_DEC_STATS_EN
  logic [15:0] err_cnt;
`endif

  tdc_therm_decoder #(.N_STAGES(32), .FINE_W(5), .COARSE_W(8)) dut (
    .clk(clk), .rstb(rstb), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .therm_in(therm_in), .phase_rev_in(phase_rev_in), .coarse_in(coarse_in),
    .out_valid(out_valid), .out_ready(out_ready), .tdc_code(tdc_code), .out_err(out_err)
`ifdef TDC_DEC_STATS_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: returns {err, coarse, fine} straight from the decoding rules.
  function automatic logic [13:0] model(input logic [31:0] th, input logic ph, input logic [7:0] co);
    int nb[N+2];
    int cc[N+1];
    int edges, first;
    logic [4:0] fine;
    logic err;
    nb[0] = 1; nb[N+1] = 0;
    for (int i = 0; i < N; i++) nb[i+1] = int'(th[i]) ^ (i % 2) ^ int'(ph);
    for (int i = 0; i < N; i++) cc[i] = ((nb[i] + nb[i+1] + nb[i+2]) >= 2) ? 1 : 0;
    cc[N] = 0;
    edges = 0; first = N;
    for (int i = 0; i < N; i++) begin
      if (cc[i] == 1 && cc[i+1] == 0) edges++;
      if (cc[i] == 0 && first == N) first = i;
    end
    if (first == N) begin fine = 5'(N - 1); err = 1'b1; end
    else begin fine = 5'(first); err = (edges > 1); end
    return {err, co, fine};
  endfunction

  task automatic gen(output logic [31:0] th, output logic ph, output logic [7:0] co);
    logic [63:0] ones;
    logic [31:0] norm, alt;
    int k, variant;
    alt = 32'hAAAAAAAA;
    k = $urandom_range(0, 32);
    variant = $urandom_range(0, 3);
    ones = (64'd1 << k) - 64'd1;
    norm = ones[31:0];
    if (variant == 1) norm[$urandom_range(0, 31)] ^= 1'b1;
    ph = 1'($urandom_range(0, 1));
    co = 8'($urandom_range(0, 255));
    th = (variant == 0) ? 32'($urandom) : (norm ^ alt ^ {32{ph}});
  endtask

  task automatic test_reset;
    rstb = 1'b0; sample_valid = 1'b0; out_ready = 1'b1;
    therm_in = '0; phase_rev_in = 1'b0; coarse_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || tdc_code !== 13'd0 || out_err !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got v=%b code=%0d err=%b want 0/0/0", out_valid, tdc_code, out_err);
    end
    total++;
    if (sample_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
    rstb = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || sample_ready !== 1'b1) begin
      bad++; $display("FAIL post_release: got v=%b rdy=%b want 0/1", out_valid, sample_ready);
    end
    exp_errs = 0;
  endtask

  task automatic test_directed;
    logic [31:0] th_t[6] = '{32'hAAAAA955, 32'h555556AA, 32'hAAAAA975, 32'hAAA5AA55, 32'h55555555, 32'hAAAAAAAA};
    logic        ph_t[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0]  co_t[6] = '{8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [12:0] code_t[6] = '{13'd106, 13'd106, 13'd10, 13'd8, 13'd31, 13'd0};
    logic        err_t[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      therm_in = th_t[v]; phase_rev_in = ph_t[v]; coarse_in = co_t[v];
      sample_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 8) begin @(posedge clk); #1; n++; end
      total++;
      if (n != 3) begin bad++; $display("FAIL latency[%0d]: got %0d edges want 3", v, n); end
      total++;
      if (tdc_code !== code_t[v] || out_err !== err_t[v]) begin
        bad++; $display("FAIL directed[%0d]: got code=%0d err=%b want code=%0d err=%b", v, tdc_code, out_err, code_t[v], err_t[v]);
      end
      if (err_t[v]) exp_errs++;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL valid_clear[%0d]: got %b want 0", v, out_valid); end
    end
`ifdef TDC_DEC_STATS_EN
    total++;
    if (err_cnt !== 16'(exp_errs)) begin bad++; $display("FAIL err_cnt_directed: got %0d want %0d", err_cnt, exp_errs); end
`endif
  endtask

  // mode 0: five back-to-back samples with out_ready low for cycles 4-7; mode 1: random traffic.
  task automatic test_stream(input int mode);
    logic [13:0] exp_q[$];
    logic [13:0] e;
    logic [31:0] p_th;
    logic        p_ph, pend, was_stall, prev_err;
    logic [7:0]  p_co;
    logic [12:0] prev_code;
    int nsamp, made, got, stalls;
    nsamp = (mode == 0) ? 5 : 300;
    made = 0; got = 0; stalls = 0; pend = 1'b0; was_stall = 1'b0;
    prev_code = '0; prev_err = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pend && made < nsamp) begin
        gen(p_th, p_ph, p_co); pend = 1'b1; made++;
      end
      if (made == nsamp && !pend && exp_q.size() == 0 && !out_valid) break;
      therm_in = p_th; phase_rev_in = p_ph; coarse_in = p_co;
      sample_valid = pend && ((mode == 0) || ($urandom_range(0, 3) != 0));
      if (mode == 0) out_ready = !(cyc >= 4 && cyc <= 7);
      else out_ready = (made == nsamp) || ($urandom_range(0, 2) != 0);
      #1;
      if (was_stall) begin
        total++;
        if (out_valid !== 1'b1 || tdc_code !== prev_code || out_err !== prev_err) begin
          bad++; $display("FAIL hold[c%0d]: got v=%b code=%0d err=%b want 1/%0d/%b", cyc, out_valid, tdc_code, out_err, prev_code, prev_err);
        end
      end
      total++;
      if (sample_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL ready[c%0d]: got %b want %b", cyc, sample_ready, !(out_valid && !out_ready));
      end
      if (!sample_ready) stalls++;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL spurious[c%0d]: got code=%0d with nothing outstanding", cyc, tdc_code);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (e[13]) exp_errs++;
          if (tdc_code !== e[12:0] || out_err !== e[13]) begin
            bad++; $display("FAIL stream[%0d]: got code=%0d err=%b want code=%0d err=%b", got, tdc_code, out_err, e[12:0], e[13]);
          end
        end
      end
      if (sample_valid && sample_ready) begin
        exp_q.push_back(model(p_th, p_ph, p_co));
        pend = 1'b0;
      end
      was_stall = out_valid && !out_ready;
      prev_code = tdc_code; prev_err = out_err;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got != nsamp || exp_q.size() != 0 || pend) begin
      bad++; $display("FAIL drain[m%0d]: got %0d results want %0d (left %0d)", mode, got, nsamp, exp_q.size());
    end
    if (mode == 0) begin
      total++;
      if (stalls != 4) begin bad++; $display("FAIL stall_cycles: got %0d want 4", stalls); end
    end
`ifdef TDC_DEC_STATS_EN
    total++;
    if (err_cnt !== 16'(exp_errs)) begin bad++; $display("FAIL err_cnt_stream: got %0d want %0d", err_cnt, exp_errs); end
`endif
  endtask

  task automatic test_reset_midstream;
    logic [31:0] th;
    logic ph;
    logic [7:0] co;
    @(posedge clk); #1;
    out_ready = 1'b1; sample_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gen(th, ph, co);
      therm_in = th; phase_rev_in = ph; coarse_in = co;
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL pipe_full: got v=%b want 1", out_valid); end
    #2 rstb = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || tdc_code !== 13'd0 || out_err !== 1'b0 || sample_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset: got v=%b code=%0d err=%b rdy=%b want 0/0/0/1", out_valid, tdc_code, out_err, sample_ready);
    end
    sample_valid = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
    exp_errs = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL stale[%0d]: got v=%b code=%0d want v=0", i, out_valid, tdc_code); end
    end
`ifdef TDC_DEC_STATS_EN
    total++;
    if (err_cnt !== 16'd0) begin bad++; $display("FAIL err_cnt_reset: got %0d want 0", err_cnt); end
`endif
  endtask

  initial begin
    total = 0; bad = 0; exp_errs = 0;
    test_reset;
    test_directed;
    test_stream(0);
    test_stream(1);
    test_reset_midstream;
    test_stream(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
